// File: rtl/ddr_user_responder.sv
// rtl/ddr_user_responder.sv - DDR controller user-interface responder backed by an internal word array
// Models busy/data_req/data_vld timing and periodic refresh stalls of the real controller core.
module ddr_user_responder #(
    parameter int ADDR_WIDTH       = 19,
    parameter int DATA_WIDTH       = 16,
    parameter int DEPTH_LOG2       = 10,
    parameter int READ_LATENCY     = 4,
    parameter int WRITE_REQ_DELAY  = 2,
    parameter int REFRESH_INTERVAL = 780,
    parameter int REFRESH_CYCLES   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            cmd,
    input  logic                  cmd_vld,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  busy_q,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  data_req_q,
    output logic [DATA_WIDTH-1:0] data_out_q,
    output logic                  data_vld_q,
    output logic [2:0]            state_q
);

    localparam int LAT_MAX  = (READ_LATENCY > WRITE_REQ_DELAY) ? READ_LATENCY : WRITE_REQ_DELAY;
    localparam int WAIT_MAX = (LAT_MAX > REFRESH_CYCLES) ? LAT_MAX : REFRESH_CYCLES;
    localparam int CW       = $clog2(WAIT_MAX + 1);
    localparam int RW       = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;

    localparam logic [2:0] CMD_READ  = 3'd1;
    localparam logic [2:0] CMD_WRITE = 3'd2;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RD_WAIT    = 3'd1,
        S_RD_VALID   = 3'd2,
        S_WR_WAIT    = 3'd3,
        S_WR_REQ     = 3'd4,
        S_WR_CAPTURE = 3'd5,
        S_REFRESH    = 3'd6
    } fsm_t;

    fsm_t                  fsm_q, fsm_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] addr_q, addr_d;
    logic [RW-1:0]         ref_cnt_q, ref_cnt_d;
    logic                  ref_pend_q, ref_pend_d;
    logic                  ref_take, ref_expire;
    logic                  busy_d, req_d, vld_d;

    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2];

    // Upper address bits alias onto the backing array.
    logic addr_hi_unused;
    assign addr_hi_unused = ^addr[ADDR_WIDTH-1:DEPTH_LOG2];

    assign state_q = fsm_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q      <= S_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            ref_cnt_q  <= '0;
            ref_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            data_req_q <= 1'b0;
            data_vld_q <= 1'b0;
            data_out_q <= '0;
        end else begin
            fsm_q      <= fsm_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            ref_cnt_q  <= ref_cnt_d;
            ref_pend_q <= ref_pend_d;
            busy_q     <= busy_d;
            data_req_q <= req_d;
            data_vld_q <= vld_d;
            if (vld_d) begin
                data_out_q <= mem_q[addr_q];
            end
        end
    end

    // Reset drops fsm_q out of WR_CAPTURE immediately, so an abandoned write never lands.
    always_ff @(posedge clk) begin
        if (fsm_q == S_WR_CAPTURE) begin
            mem_q[addr_q] <= data_in;
        end
    end

    always_comb begin
        ref_expire = 1'b0;
        ref_cnt_d  = '0;
        if (REFRESH_INTERVAL != 0) begin
            ref_expire = (ref_cnt_q == RW'(REFRESH_INTERVAL - 1));
            ref_cnt_d  = ref_expire ? '0 : ref_cnt_q + 1'b1;
        end
        ref_pend_d = ref_expire | (ref_pend_q & ~ref_take);
    end

    always_comb begin
        fsm_d    = fsm_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        ref_take = 1'b0;
        case (fsm_q)
            S_IDLE: begin
                cnt_d = '0;
                if (ref_pend_q) begin
                    fsm_d    = S_REFRESH;
                    ref_take = 1'b1;
                end else if (cmd_vld && cmd == CMD_READ) begin
                    fsm_d  = S_RD_WAIT;
                    addr_d = addr[DEPTH_LOG2-1:0];
                end else if (cmd_vld && cmd == CMD_WRITE) begin
                    fsm_d  = S_WR_WAIT;
                    addr_d = addr[DEPTH_LOG2-1:0];
                end
            end
            S_RD_WAIT: begin
                if (cnt_q == CW'(READ_LATENCY - 2)) fsm_d = S_RD_VALID;
                else                                cnt_d = cnt_q + 1'b1;
            end
            S_RD_VALID:   fsm_d = S_IDLE;
            S_WR_WAIT: begin
                if (cnt_q == CW'(WRITE_REQ_DELAY - 2)) fsm_d = S_WR_REQ;
                else                                   cnt_d = cnt_q + 1'b1;
            end
            S_WR_REQ:     fsm_d = S_WR_CAPTURE;
            S_WR_CAPTURE: fsm_d = S_IDLE;
            S_REFRESH: begin
                if (cnt_q == CW'(REFRESH_CYCLES - 1)) fsm_d = S_IDLE;
                else                                  cnt_d = cnt_q + 1'b1;
            end
            default:      fsm_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_comb begin
        busy_d = 1'b0;
        req_d  = 1'b0;
        vld_d  = 1'b0;
        case (fsm_d)
            S_RD_WAIT, S_WR_WAIT, S_WR_CAPTURE, S_REFRESH: busy_d = 1'b1;
            S_RD_VALID: vld_d = 1'b1;
            S_WR_REQ:   req_d = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ddr_user_responder.sv
// tb/tb_ddr_user_responder.sv - scoreboard bench for ddr_user_responder
module tb_ddr_user_responder;

    localparam int RL = 4;
    localparam int WD = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic [2:0]  a_cmd = '0;
    logic        a_vld = 1'b0;
    logic [18:0] a_addr = '0;
    logic [15:0] a_din = '0;
    logic        a_busy, a_req, a_dvld;
    logic [15:0] a_dout;
    logic [2:0]  a_state;

    logic [2:0]  r_cmd = '0;
    logic        r_vld = 1'b0;
    logic [18:0] r_addr = '0;
    logic [15:0] r_din = '0;
    logic        r_busy, r_req, r_dvld;
    logic [15:0] r_dout;
    logic [2:0]  r_state;

    int n_pass = 0;
    int n_total = 0;
    logic [15:0] sb_q[$];
    logic [15:0] model [1024];

    always #5 clk = ~clk;

    ddr_user_responder #(
        .ADDR_WIDTH(19), .DATA_WIDTH(16), .DEPTH_LOG2(10), .READ_LATENCY(RL),
        .WRITE_REQ_DELAY(WD), .REFRESH_INTERVAL(0), .REFRESH_CYCLES(8)
    ) u_dut_a (
        .clk(clk), .rst(rst), .cmd(a_cmd), .cmd_vld(a_vld), .addr(a_addr),
        .busy_q(a_busy), .data_in(a_din), .data_req_q(a_req),
        .data_out_q(a_dout), .data_vld_q(a_dvld), .state_q(a_state)
    );

    ddr_user_responder #(
        .ADDR_WIDTH(19), .DATA_WIDTH(16), .DEPTH_LOG2(10), .READ_LATENCY(RL),
        .WRITE_REQ_DELAY(WD), .REFRESH_INTERVAL(16), .REFRESH_CYCLES(8)
    ) u_dut_r (
        .clk(clk), .rst(rst), .cmd(r_cmd), .cmd_vld(r_vld), .addr(r_addr),
        .busy_q(r_busy), .data_in(r_din), .data_req_q(r_req),
        .data_out_q(r_dout), .data_vld_q(r_dvld), .state_q(r_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (a_dvld) begin
            chk("rd_busy_low", 32'(a_busy), 32'd0);
            if (sb_q.size() == 0) begin
                chk("rd_unexpected_vld", 32'(a_dvld), 32'd0);
            end else begin
                logic [15:0] e;
                e = sb_q.pop_front();
                chk("rd_data", 32'(a_dout), 32'(e));
            end
        end
    end

    task automatic op(input bit wr, input logic [18:0] a, input logic [15:0] d);
        int n;
        @(negedge clk);
        chk("idle_before_cmd", 32'(a_state), 32'd0);
        a_cmd  = wr ? 3'd2 : 3'd1;
        a_vld  = 1'b1;
        a_addr = a;
        a_din  = ~d;
        if (!wr) sb_q.push_back(model[a[9:0]]);
        n = wr ? WD + 1 : RL;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            if (wr) begin
                chk("wr_state", 32'(a_state), (k < WD) ? 32'd3 : (k == WD) ? 32'd4 : 32'd5);
                chk("wr_busy", 32'(a_busy), (k == WD) ? 32'd0 : 32'd1);
                chk("wr_req", 32'(a_req), (k == WD) ? 32'd1 : 32'd0);
                chk("wr_no_vld", 32'(a_dvld), 32'd0);
            end else begin
                chk("rd_state", 32'(a_state), (k < RL) ? 32'd1 : 32'd2);
                chk("rd_busy", 32'(a_busy), (k < RL) ? 32'd1 : 32'd0);
                chk("rd_vld", 32'(a_dvld), (k == RL) ? 32'd1 : 32'd0);
                chk("rd_no_req", 32'(a_req), 32'd0);
            end
            // Opposite command and address while busy must be ignored.
            a_cmd  = wr ? 3'd1 : 3'd2;
            a_addr = ~a;
            a_din  = (wr && k == n) ? d : ~d;
            if (k == n) begin
                a_vld = 1'b0;
                a_cmd = 3'd0;
            end
        end
        if (wr) model[a[9:0]] = d;
    endtask

    task automatic idle_test(input logic [2:0] c, input logic v);
        @(negedge clk);
        a_cmd = c;
        a_vld = v;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("nop_state", 32'(a_state), 32'd0);
            chk("nop_busy", 32'(a_busy), 32'd0);
            chk("nop_req", 32'(a_req), 32'd0);
        end
        a_vld = 1'b0;
        a_cmd = 3'd0;
    endtask

    task automatic refresh_test();
        int run, n_ref, first_ref, n_vld, after;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        r_cmd = 3'd1;
        r_vld = 1'b1;
        run = 0; n_ref = 0; first_ref = -1; n_vld = 0; after = 0;
        for (int c = 0; c < 104; c++) begin
            if (c > 0) @(negedge clk);
            if (after == 2) begin
                chk("r_accept_after_ref", 32'(r_state), 32'd1);
                after = 0;
            end
            if (r_state == 3'd6) begin
                if (run == 0) begin
                    n_ref++;
                    if (first_ref < 0) first_ref = c;
                end
                run++;
                chk("r_ref_busy", 32'(r_busy), 32'd1);
            end else begin
                if (run > 0) begin
                    chk("r_ref_len", run, 32'd8);
                    chk("r_idle_after_ref", 32'(r_state), 32'd0);
                    after = 2;
                end
                run = 0;
            end
            if (r_dvld) begin
                n_vld++;
                chk("r_vld_not_busy", 32'(r_busy), 32'd0);
                chk("r_vld_state", 32'(r_state), 32'd2);
            end
        end
        chk("r_ref_count", n_ref, 32'd6);
        chk("r_ref_first", first_ref, 32'd21);
        chk("r_vld_count", n_vld, 32'd11);
        r_vld = 1'b0;
        r_cmd = 3'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [18:0] ra;
        logic [15:0] rd;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_req", 32'(a_req), 32'd0);
        chk("rst_vld", 32'(a_dvld), 32'd0);
        chk("rst_dout", 32'(a_dout), 32'd0);
        chk("rst_state", 32'(a_state), 32'd0);
        chk("rst_r_state", 32'(r_state), 32'd0);
        rst = 1'b0;

        op(1'b1, 19'h00005, 16'hBEEF);
        op(1'b0, 19'h00005, 16'h0000);
        op(1'b1, 19'h00405, 16'h1234);
        op(1'b0, 19'h00005, 16'h0000);

        for (int i = 0; i < 4; i++) begin
            ra = 19'($urandom);
            rd = 16'($urandom);
            op(1'b1, ra, rd);
            op(1'b0, ra, 16'h0000);
        end
        op(1'b0, 19'h00005, 16'h0000);

        idle_test(3'd0, 1'b1);
        idle_test(3'd3, 1'b1);
        idle_test(3'd1, 1'b0);
        idle_test(3'd2, 1'b0);

        op(1'b1, 19'h00007, 16'h1111);
        op(1'b0, 19'h00007, 16'h0000);
        @(negedge clk);
        chk("rstop_idle", 32'(a_state), 32'd0);
        a_cmd  = 3'd2;
        a_vld  = 1'b1;
        a_addr = 19'h00007;
        a_din  = 16'hAAAA;
        @(negedge clk);
        chk("rstop_wr_wait", 32'(a_state), 32'd3);
        rst = 1'b1;
        #1;
        chk("rstop_state", 32'(a_state), 32'd0);
        chk("rstop_busy", 32'(a_busy), 32'd0);
        chk("rstop_req", 32'(a_req), 32'd0);
        chk("rstop_vld", 32'(a_dvld), 32'd0);
        chk("rstop_dout", 32'(a_dout), 32'd0);
        a_vld = 1'b0;
        a_cmd = 3'd0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        op(1'b0, 19'h00007, 16'h0000);

        refresh_test();

        repeat (2) @(negedge clk);
        chk("sb_empty", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
